// File: rtl/llr_eseq_tracker.sv
// rtl/llr_eseq_tracker.sv - link-layer-retry expected-sequence tracker
module llr_eseq_tracker #(
    parameter int SEQ_W  = 8,
    parameter int TMR_W  = 12,
    parameter int RTRY_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [SEQ_W-1:0]  i_register_file_llr_wrap_value,
    input  logic [TMR_W-1:0]  i_register_file_timeout_value,
    input  logic [RTRY_W-1:0] i_register_file_max_retry,
    input  logic              i_flit_valid,
    input  logic              i_flit_retryable,
    input  logic              i_flit_crc_ok,
    input  logic              i_retry_ack,
    input  logic [SEQ_W-1:0]  i_ack_eseq,
    input  logic              i_reinit_done,
    output logic [SEQ_W-1:0]  o_retry_eseq,
    output logic              o_flit_accept,
    output logic              o_flit_discard,
    output logic              o_retry_req,
    output logic              o_retry_pending,
    output logic [RTRY_W-1:0] o_num_retry,
    output logic              o_ack_err,
    output logic              o_reinit_req
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_REINIT   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [SEQ_W-1:0]  eseq_q, eseq_d;
    logic [RTRY_W-1:0] num_q, num_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              accept_q, accept_d;
    logic              discard_q, discard_d;
    logic              req_q, req_d;
    logic              ack_err_q, ack_err_d;
    logic              pending_q, pending_d;
    logic              reinit_q, reinit_d;

    logic [SEQ_W-1:0]  eff_max;
    logic [SEQ_W-1:0]  eseq_adv;
    logic [RTRY_W-1:0] num_inc;
    logic              flit_rt;
    logic              tmr_expire;

    // Derived helpers: effective wrap point, advanced sequence, saturating retry count, timer expiry.
    always_comb begin
        eff_max    = (i_register_file_llr_wrap_value == '0) ? {SEQ_W{1'b1}}
                                                            : i_register_file_llr_wrap_value;
        // ">=" also catches a wrap point lowered below the current sequence.
        eseq_adv   = (eseq_q >= eff_max) ? '0 : eseq_q + SEQ_W'(1);
        num_inc    = (num_q == {RTRY_W{1'b1}}) ? num_q : num_q + RTRY_W'(1);
        flit_rt    = i_flit_valid && i_flit_retryable;
        tmr_expire = (i_register_file_timeout_value != '0) &&
                     (tmr_q == i_register_file_timeout_value - TMR_W'(1));
    end

    // Next-state and next-output logic; ack/reinit_done outrank timeout, which outranks flits.
    always_comb begin
        state_d   = state_q;
        eseq_d    = eseq_q;
        num_d     = num_q;
        tmr_d     = tmr_q;
        accept_d  = 1'b0;
        discard_d = 1'b0;
        req_d     = 1'b0;
        ack_err_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (flit_rt) begin
                    if (i_flit_crc_ok) begin
                        eseq_d   = eseq_adv;
                        accept_d = 1'b1;
                    end else begin
                        discard_d = 1'b1;
                        req_d     = 1'b1;
                        num_d     = '0;
                        tmr_d     = '0;
                        state_d   = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                discard_d = flit_rt;
                if (i_retry_ack) begin
                    if (i_ack_eseq > eff_max) begin
                        eseq_d    = '0;
                        ack_err_d = 1'b1;
                    end else begin
                        eseq_d = i_ack_eseq;
                    end
                    num_d   = '0;
                    tmr_d   = '0;
                    state_d = ST_RUN;
                end else if (i_register_file_timeout_value != '0) begin
                    if (tmr_expire) begin
                        tmr_d = '0;
                        if (num_q == i_register_file_max_retry) begin
                            state_d = ST_REINIT;
                        end else begin
                            req_d = 1'b1;
                            num_d = num_inc;
                        end
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            ST_REINIT: begin
                discard_d = flit_rt;
                if (i_reinit_done) begin
                    eseq_d  = '0;
                    num_d   = '0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        pending_d = (state_d == ST_WAIT_ACK);
        reinit_d  = (state_d == ST_REINIT);
    end

    // State and registered-output flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_RUN;
            eseq_q    <= '0;
            num_q     <= '0;
            tmr_q     <= '0;
            accept_q  <= 1'b0;
            discard_q <= 1'b0;
            req_q     <= 1'b0;
            ack_err_q <= 1'b0;
            pending_q <= 1'b0;
            reinit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            eseq_q    <= eseq_d;
            num_q     <= num_d;
            tmr_q     <= tmr_d;
            accept_q  <= accept_d;
            discard_q <= discard_d;
            req_q     <= req_d;
            ack_err_q <= ack_err_d;
            pending_q <= pending_d;
            reinit_q  <= reinit_d;
        end
    end

    assign o_retry_eseq    = eseq_q;
    assign o_flit_accept   = accept_q;
    assign o_flit_discard  = discard_q;
    assign o_retry_req     = req_q;
    assign o_retry_pending = pending_q;
    assign o_num_retry     = num_q;
    assign o_ack_err       = ack_err_q;
    assign o_reinit_req    = reinit_q;

endmodule

// File: doc/llr_eseq_tracker.md
# llr_eseq_tracker

Parametrised link-layer-retry expected-sequence tracker for the CXL controller receive path. It counts accepted retryable flits with a programmable wrap point. On a CRC-failed retryable flit it freezes the sequence and raises a retry request, then resynchronises to the sequence number carried in the retry acknowledgement. It re-requests on a programmable timeout and escalates to a PHY re-initialisation request after a programmable number of failed attempts.

## Interface
- SEQ_W, 8: width of the expected sequence number.
- TMR_W, 12: width of the retry-ack timeout counter.
- RTRY_W, 5: width of the retry-attempt counter.

- i_clk  input  1  sole clock, rising edge.
- i_rst_n  input  1  reset; asynchronous assert, active-low.
- i_register_file_llr_wrap_value  input  SEQ_W  last sequence value before wrap; 0 means full range (2^SEQ_W-1).
- i_register_file_timeout_value  input  TMR_W  cycles to wait for ack before re-request; 0 disables the timer.
- i_register_file_max_retry  input  RTRY_W  re-requests allowed before escalation.
- i_flit_valid  input  1  a flit is presented this cycle.
- i_flit_retryable  input  1  the presented flit is retryable.
- i_flit_crc_ok  input  1  the presented flit passed CRC.
- i_retry_ack  input  1  one-cycle retry acknowledgement from the remote.
- i_ack_eseq  input  SEQ_W  sequence number carried by the ack; valid with i_retry_ack.
- i_reinit_done  input  1  PHY re-initialisation complete, one-cycle pulse.
- o_retry_eseq  output  SEQ_W  current expected sequence number.
- o_flit_accept  output  1  pulse: retryable flit accepted and counted.
- o_flit_discard  output  1  pulse: retryable flit dropped (error or not in RUN).
- o_retry_req  output  1  pulse: send retry request.
- o_retry_pending  output  1  level: state is WAIT_ACK.
- o_num_retry  output  RTRY_W  re-requests issued in the current episode.
- o_ack_err  output  1  pulse: the ack sequence number was out of range.
- o_reinit_req  output  1  level: state is REINIT.

## Operation
- eff_max = wrap_value==0 ? 2^SEQ_W-1 : wrap_value.
- Advance rule: next = (eseq >= eff_max) ? 0 : eseq+1. The ">=" case covers a wrap value lowered below the current eseq.
- Non-retryable flits (i_flit_retryable=0) are ignored in all states. No output responds to them.
- States: RUN, WAIT_ACK, REINIT. Reset state is RUN.
- RUN:
  - A valid retryable flit with crc_ok: eseq advances and o_flit_accept pulses.
  - A valid retryable flit with !crc_ok: eseq holds, o_flit_discard and o_retry_req pulse, num_retry=0, the timer clears, and the state moves to WAIT_ACK.
- WAIT_ACK:
  - Each valid retryable flit: o_flit_discard pulses and eseq holds.
  - i_retry_ack with i_ack_eseq<=eff_max: eseq loads i_ack_eseq.
  - i_retry_ack with i_ack_eseq>eff_max: eseq loads 0 and o_ack_err pulses.
  - On either ack case, the state moves to RUN and num_retry clears.
  - Timer: counts every WAIT_ACK cycle when the timeout value is nonzero. When timer == timeout_value-1 and there is no ack:
    - If num_retry == max_retry, the state moves to REINIT.
    - Otherwise o_retry_req pulses, num_retry increments (saturating at all-ones), and the timer clears.
- REINIT:
  - o_reinit_req is held high and valid retryable flits are discarded.
  - On i_reinit_done: eseq=0, num_retry=0, and the state moves to RUN.
  - i_retry_ack is ignored.
- Priority within a cycle: reset > ack/reinit_done > timeout > flit. An ack in the same cycle as the timeout expiry wins, so no re-request is issued. A flit in the ack cycle is discarded.
- Reset mid-operation: all state clears immediately.
- Reset values: o_retry_eseq=0, o_num_retry=0, and all pulse and level outputs 0.

## Timing
- All outputs are registered.
- o_retry_eseq reflects an accepted flit or ack load on the cycle after the triggering edge.
- o_flit_accept, o_flit_discard, o_retry_req and o_ack_err pulse exactly one cycle, the cycle after their cause.
- o_retry_pending and o_reinit_req rise and fall the cycle after the state transition.
- A flit presented the cycle after an ack is checked in RUN against the loaded eseq.
- Timeout T: first re-request o_retry_req appears T cycles after the initial o_retry_req pulse.
- Maximum throughput: one retryable flit per cycle.

## Test plan
- wrap=5, 8 consecutive good retryable flits -> eseq sequence 1,2,3,4,5,0,1,2; 8 accept pulses.
- wrap=0, SEQ_W=8, eseq=255, one good flit -> eseq=0.
- eseq=3, bad-CRC flit, 2 good flits, ack with ack_eseq=10 (wrap=0) ->
  - 1 retry_req, 3 discards, eseq=3 throughout WAIT_ACK;
  - eseq=10 and pending=0 the cycle after the ack.
- wrap=7, ack_eseq=9 -> eseq=0 and o_ack_err pulses once.
- timeout=4, max_retry=2, no ack -> retry_req pulses at cycles 0, 4, 8; num_retry=2; REINIT entered at cycle 12; reinit_done -> eseq=0, RUN.
- Ack coinciding with timeout expiry -> no extra retry_req, RUN next cycle.
- Assert i_rst_n low in WAIT_ACK -> all outputs 0 immediately, RUN.
